// File: rtl/riscv_fetch_pkg.sv
// Shared fetch-stage types: FSM states, queue entry layout and constants.
// Used by fetch_prefetch_queue and fetch_fifo.
package riscv_fetch_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc_plus4;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer for prefetched instructions.
// Power-of-two depth; clear wins over push/pop.
module fetch_fifo
    import riscv_fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [2*XLEN-1:0]        data_i,
    input  logic                     pop_i,
    input  logic                     clear_i,
    output logic [2*XLEN-1:0]        head_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [AW-1:0]     wr_q;
    logic [AW-1:0]     rd_q;
    logic [CW-1:0]     cnt_q;
    logic [2*XLEN-1:0] mem_q [DEPTH];

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (clear_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + 1'b1;
            if (pop_i)  rd_q <= rd_q + 1'b1;
            if (push_i && !pop_i)
                cnt_q <= cnt_q + 1'b1;
            else if (pop_i && !push_i)
                cnt_q <= cnt_q - 1'b1;
        end
    end

    // Entry storage; contents are qualified by the count, so no reset
    always_ff @(posedge clk) begin
        if (push_i && !clear_i)
            mem_q[wr_q] <= data_i;
    end

    assign head_o  = mem_q[rd_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Fetch front-end: sequential imem fetch with credit-limited prefetch queue.
// Define FETCH_QUEUE_BYPASS_EN to forward a response to decode in its arrival cycle.
module fetch_prefetch_queue
    import riscv_fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
);

    localparam int          CW      = $clog2(DEPTH + 1);
    localparam logic [CW:0] CREDITS = (CW+1)'(DEPTH);

    fetch_state_e      state_q;
    logic [31:0]       fetch_pc_q;
    logic [31:0]       rsp_pc_q;
    logic [CW-1:0]     outst_q;
    logic [CW-1:0]     disc_q;
    logic [CW-1:0]     disc_d;
    logic [CW-1:0]     pend;
    logic [CW-1:0]     occ;
    logic              has_head;
    logic              credit;
    logic              grant;
    logic              rsp_run;
    logic              byp;
    logic              push;
    logic              pop;
    fetch_entry_t      push_e;
    fetch_entry_t      head_e;
    logic [2*XLEN-1:0] head_raw;
    logic [31:0]       head_instr;
    logic [31:0]       head_pc;

    assign has_head  = (occ != '0);
    assign credit    = ({1'b0, occ} + {1'b0, outst_q}) < CREDITS;
    assign imem_req  = (state_q == ST_RUN) && !redirect && credit;
    assign imem_addr = fetch_pc_q;
    assign grant     = imem_req && imem_gnt;
    assign rsp_run   = (state_q == ST_RUN) && imem_rvalid && !redirect;

    assign head_e     = head_raw;
    assign head_instr = has_head ? head_e.instr : NOP_INSTR;
    assign head_pc    = has_head ? head_e.pc_plus4 : '0;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign byp       = rsp_run && !has_head;
    assign out_valid = has_head || byp;
    assign out_instr = byp ? imem_rdata : head_instr;
    assign out_pc    = byp ? rsp_pc_q + 32'd4 : head_pc;
`else
    assign byp       = 1'b0;
    assign out_valid = has_head;
    assign out_instr = head_instr;
    assign out_pc    = head_pc;
`endif

    assign push            = rsp_run && !(byp && out_ready);
    assign pop             = has_head && out_ready;
    assign push_e.instr    = imem_rdata;
    assign push_e.pc_plus4 = rsp_pc_q + 32'd4;

    fetch_fifo #(
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .data_i  (push_e),
        .pop_i   (pop),
        .clear_i (redirect),
        .head_o  (head_raw),
        .count_o (occ)
    );

    // Responses still owed by memory after a redirect, less one arriving now
    always_comb begin
        pend   = (state_q == ST_FLUSH) ? disc_q : outst_q;
        disc_d = pend - CW'(imem_rvalid);
        if (pend == '0) disc_d = '0;
    end

    // Control FSM with fetch PC, response PC and credit counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            outst_q    <= '0;
            disc_q     <= '0;
        end else if (redirect) begin
            fetch_pc_q <= redirect_pc & 32'hFFFF_FFFC;
            rsp_pc_q   <= redirect_pc & 32'hFFFF_FFFC;
            outst_q    <= '0;
            disc_q     <= disc_d;
            state_q    <= (disc_d != '0) ? ST_FLUSH : ST_RUN;
        end else begin
            unique case (state_q)
                ST_IDLE: state_q <= ST_RUN;
                ST_RUN: begin
                    if (grant)       fetch_pc_q <= fetch_pc_q + 32'd4;
                    if (imem_rvalid) rsp_pc_q   <= rsp_pc_q + 32'd4;
                    outst_q <= outst_q + CW'(grant) - CW'(imem_rvalid);
                end
                ST_FLUSH: begin
                    if (imem_rvalid) begin
                        disc_q <= disc_q - 1'b1;
                        if (disc_q == CW'(1)) state_q <= ST_RUN;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Randomized bench for fetch_prefetch_queue against an ordered-stream model.
// Honours FETCH_QUEUE_BYPASS_EN for the same-cycle bypass expectation.
module tb_fetch_prefetch_queue;

    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] KEY    = 32'h1234_5673;
    localparam logic [31:0] BYP_A  = 32'h1264_56E0;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam logic        BYP    = 1'b1;
`else
    localparam logic        BYP    = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    always #5 clk = ~clk;

    fetch_prefetch_queue #(
        .DEPTH       (DEPTH),
        .RESET_PC    (RST_PC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ KEY;
    endfunction

    // memory model: granted addresses awaiting response, in order
    logic [31:0] pend_addr[$];
    int          pend_rdy[$];
    int          cyc = 0;
    logic [31:0] exp_fetch;
    logic [31:0] exp_pc;
    int          p_gnt, p_rv, p_rdy, lat_max;
    logic        rd_n = 1'b0;
    logic [31:0] rd_pc_n = '0;
    logic        e_grant, e_acc, e_rsp;
    logic [31:0] e_addr;
    int          n_grant = 0;
    int          n_acc = 0;
    logic        saw_zero = 1'b0;

    task automatic drive();
        imem_gnt    = int'($urandom_range(99)) < p_gnt;
        imem_rvalid = 1'b0;
        if (pend_addr.size() > 0)
            if (pend_rdy[0] <= cyc && int'($urandom_range(99)) < p_rv)
                imem_rvalid = 1'b1;
        imem_rdata  = imem_rvalid ? mem_word(pend_addr[0]) : $urandom;
        out_ready   = int'($urandom_range(99)) < p_rdy;
        redirect    = rd_n;
        redirect_pc = rd_pc_n;
        rd_n        = 1'b0;
    endtask

    task automatic eval();
        #1;
        e_grant = imem_req && imem_gnt;
        e_acc   = out_valid && out_ready;
        e_rsp   = imem_rvalid;
        e_addr  = imem_addr;
        if (redirect) chk("req_in_redirect", imem_req, 0);
        if (e_grant)  chk("fetch_addr", imem_addr, exp_fetch);
        if (e_acc) begin
            chk("out_pc", out_pc, exp_pc + 32'd4);
            chk("out_instr", out_instr, mem_word(exp_pc));
        end
    endtask

    task automatic commit();
        @(posedge clk);
        if (e_grant) begin
            pend_addr.push_back(e_addr);
            pend_rdy.push_back(cyc + 1 + int'($urandom_range(lat_max)));
            exp_fetch = exp_fetch + 32'd4;
            n_grant++;
            if (e_addr == 32'h0) saw_zero = 1'b1;
        end
        if (e_rsp) begin
            void'(pend_addr.pop_front());
            void'(pend_rdy.pop_front());
        end
        if (e_acc) begin
            exp_pc = exp_pc + 32'd4;
            n_acc++;
        end
        if (redirect) begin
            exp_fetch = redirect_pc & 32'hFFFF_FFFC;
            exp_pc    = redirect_pc & 32'hFFFF_FFFC;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic step();
        drive();
        eval();
        commit();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n, a;
        logic got;
        rst_n = 1'b0;
        imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
        redirect = 0; redirect_pc = 0; out_ready = 0;
        exp_fetch = RST_PC; exp_pc = RST_PC;
        p_gnt = 100; p_rv = 100; p_rdy = 0; lat_max = 0;

        // reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_req", imem_req, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_instr", out_instr, 32'h0000_0013);
        chk("rst_pc", out_pc, 0);
        rst_n = 1'b1;

        // IDLE cycle, then first request
        drive(); eval();
        chk("req_idle_cycle", imem_req, 0);
        commit();
        drive(); eval();
        chk("first_req", imem_req, 1);
        chk("first_addr", imem_addr, RST_PC);
        commit();

        // backpressure: exactly DEPTH grants
        repeat (14) step();
        chk("bp_grants", n_grant, DEPTH);
        drive(); eval();
        chk("bp_req_low", imem_req, 0);
        chk("bp_valid", out_valid, 1);
        commit();

        // drain, then one instruction per cycle
        p_rdy = 100;
        repeat (8) step();
        a = n_acc;
        repeat (10) step();
        chk("stream_rate", n_acc - a, 10);

        // redirect with two outstanding
        p_rv = 0;
        for (int i = 0; i < 20; i++) begin
            if (pend_addr.size() >= 2) break;
            step();
        end
        chk("two_outstanding", pend_addr.size(), 2);
        rd_n = 1'b1; rd_pc_n = 32'h0000_2002;
        step();
        p_rv = 100;
        repeat (2) begin
            drive(); eval();
            chk("flush_no_req", imem_req, 0);
            commit();
        end
        drive(); eval();
        chk("redir_req", imem_req, 1);
        chk("redir_addr", imem_addr, 32'h0000_2000);
        commit();
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive(); eval();
            if (e_acc) begin
                chk("redir_first_pc", out_pc, 32'h0000_2004);
                got = 1'b1;
            end
            commit();
            if (got) break;
        end
        chk("redir_out_seen", got, 1);

        // address wrap
        rd_n = 1'b1; rd_pc_n = 32'hFFFF_FFFC;
        step();
        repeat (12) step();
        chk("wrap_to_zero", saw_zero, 1);

        // redirect together with a response and a pop
        p_rdy = 0;
        repeat (12) step();
        p_rdy = 100; p_rv = 0;
        for (int i = 0; i < 20; i++) begin
            if (pend_addr.size() >= 2) break;
            step();
        end
        chk("simul_valid_before", out_valid, 1);
        n = pend_addr.size();
        p_rv = 100;
        rd_n = 1'b1; rd_pc_n = 32'h0000_3000;
        drive(); eval();
        chk("simul_rsp", e_rsp, 1);
        chk("simul_pop", e_acc, 1);
        commit();
        p_rv = 0;
        drive(); eval();
        chk("simul_q_empty", out_valid, 0);
        chk("simul_req", imem_req, (n - 1 == 0) ? 1 : 0);
        commit();
        p_rv = 100;
        for (int i = 0; i < n - 1; i++) begin
            drive(); eval();
            chk("simul_discard_no_req", imem_req, 0);
            commit();
        end
        drive(); eval();
        chk("simul_req_after", imem_req, 1);
        chk("simul_addr_after", imem_addr, 32'h0000_3000);
        commit();

        // bypass latency from an empty queue
        p_gnt = 0; p_rv = 100; p_rdy = 100;
        repeat (10) step();
        chk("byp_idle_pend", pend_addr.size(), 0);
        rd_n = 1'b1; rd_pc_n = BYP_A;
        step();
        p_gnt = 100; p_rv = 0; p_rdy = 0;
        drive(); eval();
        chk("byp_req_addr", imem_addr, BYP_A);
        commit();
        p_gnt = 0; p_rv = 100;
        drive(); eval();
        chk("byp_rdata_seen", imem_rdata, 32'h0050_0093);
        chk("byp_same_cycle_valid", out_valid, BYP);
        commit();
        p_rv = 0;
        drive(); eval();
        chk("byp_next_valid", out_valid, 1);
        chk("byp_next_instr", out_instr, 32'h0050_0093);
        chk("byp_next_pc", out_pc, BYP_A + 32'd4);
        commit();

        // randomized traffic with occasional redirects
        lat_max = 3;
        a = n_acc;
        for (int i = 0; i < 3000; i++) begin
            if (i % 100 == 0) begin
                p_gnt = int'($urandom_range(30, 100));
                p_rv  = int'($urandom_range(30, 100));
                p_rdy = int'($urandom_range(20, 100));
            end
            if (int'($urandom_range(99)) < 2) begin
                rd_n    = 1'b1;
                rd_pc_n = $urandom;
            end
            step();
        end
        chk("random_progress", (n_acc - a) > 100, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
